// File: rtl/calc_pkg.sv
// Shared encodings for the multi-cycle execute unit.
// Op codes, operand-B selects and control FSM states.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRA = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B    = 2'd0,
    SRCB_INC  = 2'd1,
    SRCB_IMM  = 2'd2,
    SRCB_IMM2 = 2'd3
  } srcb_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/calc_src_mux.sv
// Operand selection for the execute unit.
// X is PC or A; Y is B, the PC increment, Imm or Imm<<1.
module calc_src_mux
  import calc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int INC   = 2
) (
  input  logic             src_a,
  input  srcb_e            src_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  // Pick both operands from their sources.
  always_comb begin
    x = src_a ? a : pc;
    y = b;
    unique case (src_b)
      SRCB_B:    y = b;
      SRCB_INC:  y = WIDTH'(INC);
      SRCB_IMM:  y = imm;
      SRCB_IMM2: y = imm << 1;
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle execute unit with start/busy/done handshake.
// Define MULTICYCLE_ALU_MUL_EN to build the iterative multiplier.
module multicycle_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int INC   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  input  logic [WIDTH-1:0] input_PC,
  input  logic [WIDTH-1:0] input_Imm,
  input  logic             input_ALUSrcA,
  input  logic [1:0]       input_ALUSrcB,
  input  logic [2:0]       input_ALUOp,
  input  logic             input_start,
  output logic [WIDTH-1:0] output_ALU,
  output logic             output_Zero,
  output logic             output_negative,
  output logic             output_carry,
  output logic             output_overflow,
  output logic             output_busy,
  output logic             output_done,
  output logic             output_illegal
);

  localparam int LW = $clog2(WIDTH);
  localparam int CW = LW + 1;
`ifdef MULTICYCLE_ALU_MUL_EN
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif

  logic [WIDTH-1:0] x_sel, y_sel;
  logic [LW-1:0]    k_amt;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] dif_w;
  alu_op_e          op_in;

  state_e           state_q, state_d;
  alu_op_e          op_q, op_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_q, alu_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;
`ifdef MULTICYCLE_ALU_MUL_EN
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH:0]   madd;
`endif

  logic [WIDTH-1:0] res;
  logic             cy, ov, upd;

  calc_src_mux #(
    .WIDTH(WIDTH),
    .INC  (INC)
  ) u_src (
    .src_a(input_ALUSrcA),
    .src_b(srcb_e'(input_ALUSrcB)),
    .a    (input_A),
    .b    (input_B),
    .pc   (input_PC),
    .imm  (input_Imm),
    .x    (x_sel),
    .y    (y_sel)
  );

  assign op_in = alu_op_e'(input_ALUOp);
  assign k_amt = y_sel[LW-1:0];
  assign sum_w = {1'b0, x_sel} + {1'b0, y_sel};
  assign dif_w = x_sel - y_sel;

  // Next state, iteration step and result/flag capture.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    alu_d   = alu_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    ill_d   = 1'b0;
    res     = '0;
    cy      = 1'b0;
    ov      = 1'b0;
    upd     = 1'b0;
`ifdef MULTICYCLE_ALU_MUL_EN
    x_d     = x_q;
    madd    = '0;
`endif
    if (state_q == ST_RUN) begin
      case (op_q)
        OP_SLL: begin
          res    = {prod_q[WIDTH-2:0], 1'b0};
          cy     = prod_q[WIDTH-1];
          prod_d[WIDTH-1:0] = res;
        end
        OP_SRA: begin
          res    = {prod_q[WIDTH-1], prod_q[WIDTH-1:1]};
          cy     = prod_q[0];
          prod_d[WIDTH-1:0] = res;
        end
`ifdef MULTICYCLE_ALU_MUL_EN
        OP_MUL: begin
          madd   = {1'b0, prod_q[PW-1:WIDTH]}
                 + (prod_q[0] ? {1'b0, x_q} : '0);
          prod_d = {madd, prod_q[WIDTH-1:1]};
          res    = prod_d[WIDTH-1:0];
          ov     = |prod_d[PW-1:WIDTH];
        end
`endif
        default: ;
      endcase
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = ST_DONE;
        upd     = 1'b1;
      end
    end else begin
      if (state_q == ST_DONE) state_d = ST_IDLE;
      if (input_start) begin
        op_d = op_in;
        unique case (op_in)
          OP_ADD: begin
            res = sum_w[WIDTH-1:0];
            cy  = sum_w[WIDTH];
            ov  = (x_sel[WIDTH-1] == y_sel[WIDTH-1])
               && (res[WIDTH-1] != x_sel[WIDTH-1]);
            upd = 1'b1;
            state_d = ST_DONE;
          end
          OP_SUB: begin
            res = dif_w;
            cy  = (x_sel >= y_sel);
            ov  = (x_sel[WIDTH-1] != y_sel[WIDTH-1])
               && (res[WIDTH-1] != x_sel[WIDTH-1]);
            upd = 1'b1;
            state_d = ST_DONE;
          end
          OP_AND: begin
            res = x_sel & y_sel;
            upd = 1'b1;
            state_d = ST_DONE;
          end
          OP_OR: begin
            res = x_sel | y_sel;
            upd = 1'b1;
            state_d = ST_DONE;
          end
          OP_XOR: begin
            res = x_sel ^ y_sel;
            upd = 1'b1;
            state_d = ST_DONE;
          end
          OP_SLL, OP_SRA: begin
            if (k_amt == '0) begin
              res = x_sel;
              upd = 1'b1;
              state_d = ST_DONE;
            end else begin
              prod_d  = PW'(x_sel);
              cnt_d   = {1'b0, k_amt};
              state_d = ST_RUN;
            end
          end
          OP_MUL: begin
`ifdef MULTICYCLE_ALU_MUL_EN
            prod_d  = PW'(y_sel);
            x_d     = x_sel;
            cnt_d   = CW'(WIDTH);
            state_d = ST_RUN;
`else
            ill_d   = 1'b1;
            state_d = ST_DONE;
`endif
          end
        endcase
      end
    end
    if (upd) begin
      alu_d   = res;
      zero_d  = (res == '0);
      neg_d   = res[WIDTH-1];
      carry_d = cy;
      ovf_d   = ov;
    end
  end

  // State, datapath and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      prod_q  <= '0;
      cnt_q   <= '0;
      alu_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
`ifdef MULTICYCLE_ALU_MUL_EN
      x_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      alu_q   <= alu_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
`ifdef MULTICYCLE_ALU_MUL_EN
      x_q     <= x_d;
`endif
    end
  end

  assign output_ALU      = alu_q;
  assign output_Zero     = zero_q;
  assign output_negative = neg_q;
  assign output_carry    = carry_q;
  assign output_overflow = ovf_q;
  assign output_busy     = (state_q == ST_RUN);
  assign output_done     = (state_q == ST_DONE);
  assign output_illegal  = ill_q;

endmodule
